// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - elastic valid/ready pipeline register chain with flush and hold
// Stage 0 takes producer data, stage DEPTH-1 feeds the consumer; bubbles collapse toward the output.
module pipe_stage_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             hold,
   input  logic [DEPTH-1:0] flush,
   output logic [CW-1:0]    occupancy
);

   logic [DEPTH-1:0] valid_q;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH:0]   ready;
   logic [DEPTH-1:0] src_live;
   logic [WIDTH-1:0] src_data [DEPTH];
   logic [DEPTH-1:0] load;
   logic [DEPTH-1:0] valid_d;
   logic [CW-1:0]    occ_d;
   logic             avail;

   // ready[i] flattened: room exists if this stage or any older one is empty, or the consumer takes one
   always_comb begin
      avail = out_ready;
      ready = '0;
      ready[DEPTH] = out_ready & ~hold;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         avail = avail | ~valid_q[i] | flush[i];
         ready[i] = ~hold & avail;
      end
   end

   always_comb begin
      src_live[0] = in_valid;
      src_data[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         src_live[i] = valid_q[i-1] & ~flush[i-1];
         src_data[i] = data_q[i-1];
      end
   end

   always_comb begin
      valid_d = valid_q;
      load    = '0;
      occ_d   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         load[i] = ready[i] & src_live[i];
         if (load[i])
            valid_d[i] = 1'b1;
         else if ((ready[i+1] & valid_q[i]) | flush[i])
            valid_d[i] = 1'b0;
         occ_d = occ_d + CW'(valid_d[i]);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q   <= '0;
         occupancy <= '0;
         for (int i = 0; i < DEPTH; i++)
            data_q[i] <= '0;
      end else begin
         valid_q   <= valid_d;
         occupancy <= occ_d;
         for (int i = 0; i < DEPTH; i++)
            if (load[i])
               data_q[i] <= src_data[i];
      end
   end

   assign in_ready  = ready[0];
   assign out_valid = valid_q[DEPTH-1] & ~flush[DEPTH-1] & ~hold;
   assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - scoreboard bench for pipe_stage_chain (WIDTH=32, DEPTH=4)
module tb_pipe_stage_chain;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clock = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             hold;
   logic [DEPTH-1:0] flush;
   logic [CW-1:0]    occupancy;

   int n_cmp = 0;
   int n_bad = 0;
   logic [WIDTH-1:0] sb [$];

   logic             fired;
   logic             have;
   logic [WIDTH-1:0] got;
   logic [WIDTH-1:0] want;

   pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .hold(hold), .flush(flush), .occupancy(occupancy)
   );

   always #5 clock = ~clock;

   // Bookkeeping for one clock: push accepted input, pop expected output; callers compare.
   task automatic cycle(output logic f, output logic [WIDTH-1:0] g, output logic [WIDTH-1:0] w,
                        output logic h);
      #1;
      f = out_valid && out_ready;
      g = out_data;
      w = '0;
      h = 1'b0;
      if (in_valid && in_ready) sb.push_back(in_data);
      if (f && sb.size() > 0) begin
         w = sb.pop_front();
         h = 1'b1;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; hold = 1'b0; flush = '0;
      #12;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid act=%0b req=0", out_valid); end
      n_cmp++; if (occupancy !== 0) begin n_bad++; $display("FAIL reset_occupancy act=%0d req=0", occupancy); end
      n_cmp++; if (out_data !== 0) begin n_bad++; $display("FAIL reset_out_data act=%0h req=0", out_data); end
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready act=%0b req=1", in_ready); end
   endtask

   task automatic test_stream();
      int sent = 0, outs = 0, first_acc = -1, first_ov = -1;
      for (int c = 0; c < 30 && outs < 8; c++) begin
         in_valid = (sent < 8); in_data = 32'h10 + sent; out_ready = 1'b1;
         #1;
         if (in_valid && in_ready) begin if (first_acc < 0) first_acc = c; sent++; end
         if (out_valid && first_ov < 0) first_ov = c;
         cycle(fired, got, want, have);
         if (fired) begin
            outs++; n_cmp++;
            if (!have || got !== want) begin n_bad++; $display("FAIL stream_order act=%0h req=%0h", got, want); end
         end
         if (c >= 3 && c <= 7) begin
            n_cmp++; if (occupancy !== 4) begin n_bad++; $display("FAIL stream_occupancy act=%0d req=4", occupancy); end
         end
      end
      in_valid = 1'b0;
      n_cmp++; if (first_ov - first_acc !== 4) begin n_bad++; $display("FAIL stream_latency act=%0d req=4", first_ov - first_acc); end
      n_cmp++; if (outs !== 8) begin n_bad++; $display("FAIL stream_count act=%0d req=8", outs); end
   endtask

   task automatic test_full();
      int sent = 0, outs = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 10 && sent < 4; c++) begin
         in_valid = 1'b1; in_data = 32'h20 + sent;
         #1; if (in_ready) sent++;
         cycle(fired, got, want, have);
      end
      in_valid = 1'b1; in_data = 32'h99;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready act=%0b req=0", in_ready); end
      n_cmp++; if (occupancy !== 4) begin n_bad++; $display("FAIL full_occupancy act=%0d req=4", occupancy); end
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_release_in_ready act=%0b req=1", in_ready); end
      for (int c = 0; c < 12 && sb.size() > 0; c++) begin
         cycle(fired, got, want, have);
         if (fired) begin
            outs++; n_cmp++;
            if (!have || got !== want) begin n_bad++; $display("FAIL full_drain act=%0h req=%0h", got, want); end
         end
      end
      n_cmp++; if (outs !== 4) begin n_bad++; $display("FAIL full_drain_count act=%0d req=4", outs); end
   endtask

   task automatic test_collapse();
      logic [WIDTH-1:0] stim_d [8] = '{32'hA, 0, 0, 32'hB, 0, 0, 0, 0};
      logic             stim_v [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
      out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         in_valid = stim_v[c]; in_data = stim_d[c];
         cycle(fired, got, want, have);
      end
      in_valid = 1'b0;
      #1;
      n_cmp++; if (occupancy !== 2) begin n_bad++; $display("FAIL collapse_occupancy act=%0d req=2", occupancy); end
      n_cmp++; if (out_data !== 32'hA) begin n_bad++; $display("FAIL collapse_head act=%0h req=a", out_data); end
      out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL collapse_no_bubble act=%0b req=1", out_valid); end
         cycle(fired, got, want, have);
         if (fired) begin
            n_cmp++;
            if (!have || got !== want) begin n_bad++; $display("FAIL collapse_order act=%0h req=%0h", got, want); end
         end
      end
      n_cmp++; if (occupancy !== 0) begin n_bad++; $display("FAIL collapse_empty act=%0d req=0", occupancy); end
   endtask

   task automatic test_flush();
      int sent = 0, outs = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 10 && sent < 4; c++) begin
         in_valid = 1'b1; in_data = 32'h1 + sent;
         #1; if (in_ready) sent++;
         cycle(fired, got, want, have);
      end
      in_valid = 1'b0; flush = 4'b0100;
      sb.delete(1);
      cycle(fired, got, want, have);
      flush = '0;
      n_cmp++; if (occupancy !== 3) begin n_bad++; $display("FAIL flush_occupancy act=%0d req=3", occupancy); end
      out_ready = 1'b1;
      for (int c = 0; c < 12 && sb.size() > 0; c++) begin
         cycle(fired, got, want, have);
         if (fired) begin
            outs++; n_cmp++;
            if (!have || got !== want) begin n_bad++; $display("FAIL flush_order act=%0h req=%0h", got, want); end
         end
      end
      #1;
      n_cmp++; if (out_valid !== 1'b0 || outs !== 3) begin
         n_bad++; $display("FAIL flush_count act=%0d req=3", outs);
      end
   endtask

   task automatic test_hold();
      int sent = 0, outs = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 10 && sent < 4; c++) begin
         in_valid = 1'b1; in_data = 32'h30 + sent;
         #1; if (in_ready) sent++;
         cycle(fired, got, want, have);
      end
      hold = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h30 + sent;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_out_valid act=%0b req=0", out_valid); end
         n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready act=%0b req=0", in_ready); end
         cycle(fired, got, want, have);
         n_cmp++; if (occupancy !== 4) begin n_bad++; $display("FAIL hold_occupancy act=%0d req=4", occupancy); end
      end
      hold = 1'b0;
      for (int c = 0; c < 30 && (sent < 8 || sb.size() > 0); c++) begin
         in_valid = (sent < 8); in_data = 32'h30 + sent;
         #1; if (in_valid && in_ready) sent++;
         cycle(fired, got, want, have);
         if (fired) begin
            outs++; n_cmp++;
            if (!have || got !== want) begin n_bad++; $display("FAIL hold_resume act=%0h req=%0h", got, want); end
         end
      end
      in_valid = 1'b0;
      n_cmp++; if (outs !== 8) begin n_bad++; $display("FAIL hold_count act=%0d req=8", outs); end
   endtask

   task automatic test_reset_mid();
      int sent = 0, first_acc = -1, first_ov = -1;
      out_ready = 1'b0;
      for (int c = 0; c < 10 && sent < 3; c++) begin
         in_valid = 1'b1; in_data = 32'h40 + sent;
         #1; if (in_ready) sent++;
         cycle(fired, got, want, have);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      n_cmp++; if (occupancy !== 3) begin n_bad++; $display("FAIL midreset_pre_occupancy act=%0d req=3", occupancy); end
      reset = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid act=%0b req=0", out_valid); end
      n_cmp++; if (occupancy !== 0) begin n_bad++; $display("FAIL midreset_occupancy act=%0d req=0", occupancy); end
      sb.delete();
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;
      sent = 0;
      for (int c = 0; c < 12 && first_ov < 0; c++) begin
         in_valid = (sent < 1); in_data = 32'h55;
         #1;
         if (in_valid && in_ready) begin first_acc = c; sent++; end
         if (out_valid) first_ov = c;
         cycle(fired, got, want, have);
         if (fired) begin
            n_cmp++;
            if (!have || got !== want) begin n_bad++; $display("FAIL midreset_data act=%0h req=%0h", got, want); end
         end
      end
      in_valid = 1'b0;
      n_cmp++; if (first_acc !== 0 || first_ov !== 4) begin
         n_bad++; $display("FAIL midreset_latency act=%0d req=4", first_ov - first_acc);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_collapse();
      test_flush();
      test_hold();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
